sccb_config_sequencer: RTL and testbench

- Upstream feeder for the SCCB/I2C write engine (`i2c_interface`, send/taken handshake) that programs the camera sensor after power-up.
- Walks a fixed table of {register, value} pairs. Presents each pair with the device ID, holds `send` until `taken`, and honours embedded delay and end markers.
- Asserts `done` once the last write has drained, so downstream capture logic can start.

---
 rtl/sccb_config_sequencer.sv | 148 ++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_sequencer.sv
// Walks a fixed {register, value} table after power-up and feeds each pair to the
// SCCB write engine over a send/taken handshake, honouring delay and end markers.
module sccb_config_sequencer #(
  parameter logic [7:0]  DEVICE_ID      = 8'h42,
  parameter int unsigned STARTUP_CYCLES = 1000000,
  parameter int unsigned DELAY_CYCLES   = 500000,
  parameter int unsigned DRAIN_CYCLES   = 8192,
  parameter int unsigned ROM_DEPTH      = 64
) (
  input  logic       clk_50Mhz,
  input  logic       rst,
  input  logic       start,
  input  logic       taken,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] register,
  output logic [7:0] value,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PAUSE_CYCLES = DRAIN_CYCLES + DELAY_CYCLES;
  localparam int unsigned COUNT_MAX    = (STARTUP_CYCLES > PAUSE_CYCLES) ? STARTUP_CYCLES
                                                                         : PAUSE_CYCLES;
  localparam int unsigned CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int unsigned AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] PAUSE_LAST   = CW'(PAUSE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST   = CW'(DRAIN_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST    = AW'(ROM_DEPTH - 1);

  localparam logic [15:0] MARK_END   = 16'hFFFF;
  localparam logic [15:0] MARK_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    StPowerup,
    StFetch,
    StDecode,
    StSend,
    StDelay,
    StDrain,
    StDone
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [AW-1:0]  addr;
  logic [AW-1:0]  addr_next;
  logic [CW-1:0]  counter;
  logic [CW-1:0]  counter_next;
  logic [7:0]     register_next;
  logic [7:0]     value_next;
  logic [15:0]    rom_entry;
  logic [15:0]    rom_data;

  // Configuration table; every entry past the listed ones reads as an end marker.
  always_comb begin
    rom_entry = MARK_END;
    case (int'(addr))
      0:       rom_entry = 16'h1280;
      1:       rom_entry = MARK_DELAY;
      2:       rom_entry = 16'h1204;
      3:       rom_entry = 16'h1100;
      4:       rom_entry = 16'h0C00;
      5:       rom_entry = 16'h3E00;
      6:       rom_entry = 16'h40D0;
      default: rom_entry = MARK_END;
    endcase
  end

  always_ff @(posedge clk_50Mhz) begin
    rom_data <= rom_entry;
  end

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      state <= StPowerup;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      addr     <= '0;
      counter  <= '0;
      register <= '0;
      value    <= '0;
    end else begin
      addr     <= addr_next;
      counter  <= counter_next;
      register <= register_next;
      value    <= value_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StPowerup: if (counter == STARTUP_LAST) state_next = StFetch;
      StFetch:   state_next = StDecode;
      StDecode: begin
        // The last table slot ends the run whatever it holds, so addr never wraps.
        if (rom_data == MARK_END || addr == ADDR_LAST) begin
          state_next = StDrain;
        end else if (rom_data == MARK_DELAY) begin
          state_next = StDelay;
        end else begin
          state_next = StSend;
        end
      end
      StSend:    if (taken) state_next = StFetch;
      StDelay:   if (counter == PAUSE_LAST) state_next = StFetch;
      StDrain:   if (counter == DRAIN_LAST) state_next = StDone;
      StDone:    if (start) state_next = StPowerup;
      default:   state_next = StPowerup;
    endcase
  end

  always_comb begin
    send          = (state == StSend);
    done          = (state == StDone);
    busy          = (state != StDone);
    id            = DEVICE_ID;
    addr_next     = addr;
    counter_next  = '0;
    register_next = register;
    value_next    = value;
    unique case (state)
      StPowerup, StDelay, StDrain: begin
        if (state_next == state) counter_next = counter + 1'b1;
      end
      StDecode: begin
        if (state_next == StSend) begin
          register_next = rom_data[15:8];
          value_next    = rom_data[7:0];
        end else if (state_next == StDelay) begin
          addr_next = addr + 1'b1;
        end
      end
      StSend: if (taken) addr_next = addr + 1'b1;
      StDone: if (start) addr_next = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: directed vector table, randomized engine/stimulus runs
// checked against a table-walking reference model, and a short-ROM boundary instance.
module tb_sccb_config_sequencer;

  localparam int ST    = 120;
  localparam int DL    = 200;
  localparam int DR    = 40;
  localparam int PAUSE = DR + DL;
  localparam logic [7:0] DEV = 8'h42;

  logic       clk_50Mhz = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       taken = 1'b0;
  logic       send, busy, done;
  logic [7:0] id, register, value;
  logic       start2 = 1'b0;
  logic       taken2 = 1'b0;
  logic       send2, busy2, done2;
  logic [7:0] id2, register2, value2;

  always #10 clk_50Mhz = ~clk_50Mhz;

  sccb_config_sequencer #(
    .DEVICE_ID(DEV), .STARTUP_CYCLES(ST), .DELAY_CYCLES(DL), .DRAIN_CYCLES(DR), .ROM_DEPTH(64)
  ) dut (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .start(start), .taken(taken), .send(send), .id(id),
    .register(register), .value(value), .busy(busy), .done(done)
  );

  sccb_config_sequencer #(
    .DEVICE_ID(DEV), .STARTUP_CYCLES(ST), .DELAY_CYCLES(DL), .DRAIN_CYCLES(DR), .ROM_DEPTH(4)
  ) dut_short (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .start(start2), .taken(taken2), .send(send2), .id(id2),
    .register(register2), .value(value2), .busy(busy2), .done(done2)
  );

  typedef struct {
    int         n;
    logic       tk;
    logic       st;
    logic       e_send;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_reg;
    logic [7:0] e_val;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int         gap;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   done_gap;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic       mon_en = 1'b0, eng_en = 1'b0, spur_en = 1'b0;
  logic       send_prev, done_prev, rose, unstable, run_done;
  logic [7:0] cur_r, cur_v;
  int         idx, ref_edge, eng_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected writes and cycle gaps, derived by walking the table: each write is 2 cycles
  // after its reference edge, each delay marker adds PAUSE plus its own fetch/decode.
  function automatic void build_model(input int depth);
    logic [15:0] tbl [0:7];
    logic [15:0] e;
    wr_t         w;
    int          gap;
    tbl = '{16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h40D0, 16'hFFFF};
    exp_q.delete();
    gap = 2;
    for (int i = 0; i < depth; i++) begin
      e = (i < 8) ? tbl[i] : 16'hFFFF;
      if (e == 16'hFFFF || i == depth - 1) break;
      if (e == 16'hFFF0) begin
        gap += PAUSE + 2;
      end else begin
        w.r = e[15:8];
        w.v = e[7:0];
        w.gap = gap;
        exp_q.push_back(w);
        gap = 2;
      end
    end
    done_gap = gap + DR;
  endfunction

  task automatic monitor();
    rose = send && !send_prev;
    if (rose) begin
      if (idx >= exp_q.size()) begin
        check("extra_write", idx + 1, exp_q.size());
      end else begin
        check("pair", {id, register, value}, {DEV, exp_q[idx].r, exp_q[idx].v});
        check("rise_cycle", cyc, ref_edge + exp_q[idx].gap);
      end
      cur_r = register;
      cur_v = value;
      unstable = 1'b0;
    end else if (send && (register != cur_r || value != cur_v)) begin
      unstable = 1'b1;
    end
    if (done && !done_prev) begin
      check("writes_before_done", idx, exp_q.size());
      check("done_cycle", cyc, ref_edge + done_gap);
      run_done = 1'b1;
    end
    send_prev = send;
    done_prev = done;
  endtask

  task automatic engine();
    taken = 1'b0;
    start = 1'b0;
    if (rose) begin
      eng_cnt = $urandom_range(1, 40);
    end else if (send && eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        taken = 1'b1;
        check("hold_stable", unstable, 0);
        idx++;
        ref_edge = cyc + 1;
      end
    end else if (!send && spur_en && $urandom_range(0, 7) == 0) begin
      taken = 1'b1;
    end
    if (busy && spur_en && $urandom_range(0, 15) == 0) start = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_50Mhz);
    cyc++;
    @(negedge clk_50Mhz);
    if (mon_en) monitor();
    if (eng_en) engine();
  endtask

  task automatic add_vec(input int n, input logic tk, input logic st, input logic es,
                         input logic eb, input logic ed, input logic [7:0] er,
                         input logic [7:0] ev);
    vec_t v;
    v.n = n; v.tk = tk; v.st = st; v.e_send = es; v.e_busy = eb; v.e_done = ed;
    v.e_reg = er; v.e_val = ev;
    vecs.push_back(v);
  endtask

  task automatic random_run(input string name);
    int limit;
    limit = cyc + 5000;
    while (!run_done && cyc < limit) tick();
    if (!run_done) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [7:0] got_r[$];
    logic [7:0] got_v[$];
    logic       s2prev;
    int         limit;

    // Cycle counts are edges since reset release.
    add_vec(0,         0, 0, 0, 1, 0, 8'h00, 8'h00);  // reset state
    add_vec(10,        1, 0, 0, 1, 0, 8'h00, 8'h00);  // taken during POWERUP ignored
    add_vec(ST - 11,   0, 0, 0, 1, 0, 8'h00, 8'h00);  // last POWERUP cycle
    add_vec(2,         0, 0, 0, 1, 0, 8'h00, 8'h00);  // DECODE
    add_vec(1,         0, 0, 1, 1, 0, 8'h12, 8'h80);  // first send at ST+2
    add_vec(2000,      0, 1, 1, 1, 0, 8'h12, 8'h80);  // stalled, start ignored
    add_vec(1,         1, 0, 0, 1, 0, 8'h12, 8'h80);  // taken drops send
    add_vec(2,         0, 0, 0, 1, 0, 8'h12, 8'h80);  // delay marker decoded
    add_vec(PAUSE - 1, 1, 1, 0, 1, 0, 8'h12, 8'h80);  // last DELAY cycle, spurious inputs
    add_vec(2,         0, 0, 0, 1, 0, 8'h12, 8'h80);  // FETCH, DECODE
    add_vec(1,         0, 0, 1, 1, 0, 8'h12, 8'h04);  // second write

    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      taken = vecs[i].tk;
      start = vecs[i].st;
      repeat (vecs[i].n) tick();
      taken = 1'b0;
      start = 1'b0;
      check($sformatf("vec%0d", i), {send, busy, done, register, value, id},
            {vecs[i].e_send, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_reg, vecs[i].e_val, DEV});
    end

    rst = 1'b1;
    tick();
    check("reset_mid_send", {send, done, busy, register, value}, {1'b0, 1'b0, 1'b1, 16'h0000});
    rst = 1'b0;

    build_model(64);
    idx = 0; ref_edge = cyc + ST; run_done = 1'b0; eng_cnt = 0;
    send_prev = send; done_prev = done;
    mon_en = 1'b1; eng_en = 1'b1; spur_en = 1'b1;
    random_run("run1");

    spur_en = 1'b0;
    repeat (20) tick();
    check("done_hold", {send, busy, done}, 3'b001);
    start = 1'b1;
    tick();
    check("restart", {done, busy}, 2'b01);
    idx = 0; ref_edge = cyc + ST; run_done = 1'b0;
    spur_en = 1'b1;
    random_run("run2");

    // Short ROM: the last slot ends the run even though it holds a write.
    mon_en = 1'b0; eng_en = 1'b0; taken = 1'b0; start = 1'b0;
    build_model(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s2prev = 1'b0;
    limit = cyc + 3000;
    while (!done2 && cyc < limit) begin
      tick();
      if (send2 && !s2prev) begin
        got_r.push_back(register2);
        got_v.push_back(value2);
      end
      s2prev = send2;
      taken2 = send2;
    end
    check("short_done", done2, 1);
    check("short_count", got_r.size(), exp_q.size());
    for (int i = 0; i < got_r.size() && i < exp_q.size(); i++) begin
      check($sformatf("short_pair%0d", i), {got_r[i], got_v[i]}, {exp_q[i].r, exp_q[i].v});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
